// File: rtl/dijkstra_lane_engine.sv
// Single-source shortest-path engine relaxing LANES edge weights per memory word.
// Optional DIJKSTRA_EARLY_EXIT_EN: stop as soon as the destination node is visited.
module dijkstra_lane_engine #(
    parameter int unsigned MAX_NODES   = 16,
    parameter int unsigned INDEX_WIDTH = 4,
    parameter int unsigned VALUE_WIDTH = 8,
    parameter int unsigned LANES       = 2,
    parameter int unsigned MADDR_WIDTH = 16,
    parameter int unsigned MDATA_WIDTH = LANES * VALUE_WIDTH
) (
    input  logic                   clock_i,
    input  logic                   reset_ni,
    input  logic                   start_i,
    input  logic [INDEX_WIDTH-1:0] source_i,
    input  logic [INDEX_WIDTH-1:0] destination_i,
    input  logic [INDEX_WIDTH:0]   number_of_nodes_i,
    input  logic [MADDR_WIDTH-1:0] base_address_i,
    output logic                   mem_read_enable_o,
    output logic [MADDR_WIDTH-1:0] mem_addr_o,
    input  logic                   mem_read_ready_i,
    input  logic [MDATA_WIDTH-1:0] mem_read_data_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic                   reachable_o,
    output logic [VALUE_WIDTH-1:0] distance_o,
    input  logic [INDEX_WIDTH-1:0] prev_query_index_i,
    output logic [INDEX_WIDTH-1:0] prev_query_data_o
);
    localparam int unsigned Slots = 1 << INDEX_WIDTH;
    localparam int unsigned NW    = INDEX_WIDTH + 1;
    localparam logic [VALUE_WIDTH-1:0] Inf = '1;

    typedef enum logic [2:0] {StIdle, StInit, StScan, StVisit, StFetch, StRelax, StDone} state_e;

    state_e                 state_q;
    logic [INDEX_WIDTH-1:0] src_q, dst_q, scan_idx_q, min_idx_q, cur_q, grp_q;
    logic [NW-1:0]          n_q, num_grp_q;
    logic [MADDR_WIDTH-1:0] base_q, mem_addr_q;
    logic [VALUE_WIDTH-1:0] dist_q [Slots];
    logic [INDEX_WIDTH-1:0] prev_q [Slots];
    logic [Slots-1:0]       visited_q;
    logic [VALUE_WIDTH-1:0] min_val_q, distance_q;
    logic                   min_found_q, mem_en_q, busy_q, done_q, error_q, reachable_q;
    logic [MDATA_WIDTH-1:0] rdata_q;

    logic                   cfg_err, last_scan, last_grp, visit_stop;
    logic [NW-1:0]          num_grp_calc;
    logic [VALUE_WIDTH-1:0] lane_alt [LANES];
    logic [INDEX_WIDTH-1:0] lane_idx [LANES];
    logic [LANES-1:0]       lane_upd;

    assign cfg_err = (n_q == '0) || (int'(n_q) > int'(MAX_NODES)) ||
                     ({1'b0, src_q} >= n_q) || ({1'b0, dst_q} >= n_q);
    assign num_grp_calc = NW'((int'(n_q) + int'(LANES) - 1) / int'(LANES));
    assign last_scan = ({1'b0, scan_idx_q} == n_q - NW'(1));
    assign last_grp  = (({1'b0, grp_q} + NW'(1)) >= num_grp_q);
`ifdef DIJKSTRA_EARLY_EXIT_EN
    assign visit_stop = !min_found_q || (min_val_q == Inf) || (min_idx_q == dst_q);
`else
    assign visit_stop = !min_found_q || (min_val_q == Inf);
`endif

    // Per-lane relaxation candidate; a carry out of the add saturates to INF, which never wins.
    always_comb begin
        lane_upd = '0;
        for (int j = 0; j < int'(LANES); j++) begin
            logic [VALUE_WIDTH-1:0] w;
            logic [VALUE_WIDTH:0]   sum;
            int                     k;
            w           = mem_read_data_i[0 +: VALUE_WIDTH];
            w           = rdata_q[j*VALUE_WIDTH +: VALUE_WIDTH];
            k           = int'(grp_q) * int'(LANES) + j;
            lane_idx[j] = k[INDEX_WIDTH-1:0];
            sum         = {1'b0, dist_q[cur_q]} + {1'b0, w};
            lane_alt[j] = sum[VALUE_WIDTH] ? Inf : sum[VALUE_WIDTH-1:0];
            lane_upd[j] = (k < int'(n_q)) && !visited_q[lane_idx[j]] && (w != Inf) &&
                          (lane_alt[j] < dist_q[lane_idx[j]]);
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            src_q       <= '0;
            dst_q       <= '0;
            n_q         <= '0;
            base_q      <= '0;
            num_grp_q   <= '0;
            scan_idx_q  <= '0;
            min_idx_q   <= '0;
            min_val_q   <= Inf;
            min_found_q <= 1'b0;
            cur_q       <= '0;
            grp_q       <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            reachable_q <= 1'b0;
            distance_q  <= '0;
            visited_q   <= '0;
            for (int i = 0; i < int'(Slots); i++) begin
                dist_q[i] <= Inf;
                prev_q[i] <= '1;
            end
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        src_q       <= source_i;
                        dst_q       <= destination_i;
                        n_q         <= number_of_nodes_i;
                        base_q      <= base_address_i;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        reachable_q <= 1'b0;
                        distance_q  <= '0;
                        state_q     <= StInit;
                    end
                end
                StInit: begin
                    visited_q <= '0;
                    for (int i = 0; i < int'(Slots); i++) begin
                        dist_q[i] <= Inf;
                        prev_q[i] <= '1;
                    end
                    dist_q[src_q] <= '0;
                    num_grp_q     <= num_grp_calc;
                    if (cfg_err) begin
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        scan_idx_q  <= '0;
                        min_found_q <= 1'b0;
                        min_val_q   <= Inf;
                        state_q     <= StScan;
                    end
                end
                StScan: begin
                    if (!visited_q[scan_idx_q] &&
                        (!min_found_q || dist_q[scan_idx_q] < min_val_q)) begin
                        min_idx_q   <= scan_idx_q;
                        min_val_q   <= dist_q[scan_idx_q];
                        min_found_q <= 1'b1;
                    end
                    if (last_scan) state_q <= StVisit;
                    else scan_idx_q <= scan_idx_q + 1'b1;
                end
                StVisit: begin
                    if (visit_stop) begin
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        reachable_q <= (dist_q[dst_q] != Inf);
                        distance_q  <= dist_q[dst_q];
                        state_q     <= StDone;
                    end else begin
                        cur_q                <= min_idx_q;
                        visited_q[min_idx_q] <= 1'b1;
                        grp_q                <= '0;
                        mem_en_q             <= 1'b1;
                        mem_addr_q           <= base_q + MADDR_WIDTH'(min_idx_q) *
                                                MADDR_WIDTH'(num_grp_q);
                        state_q              <= StFetch;
                    end
                end
                StFetch: begin
                    if (mem_read_ready_i) begin
                        rdata_q  <= mem_read_data_i;
                        mem_en_q <= 1'b0;
                        state_q  <= StRelax;
                    end
                end
                StRelax: begin
                    for (int j = 0; j < int'(LANES); j++) begin
                        if (lane_upd[j]) begin
                            dist_q[lane_idx[j]] <= lane_alt[j];
                            prev_q[lane_idx[j]] <= cur_q;
                        end
                    end
                    if (!last_grp) begin
                        grp_q      <= grp_q + 1'b1;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= mem_addr_q + 1'b1;
                        state_q    <= StFetch;
                    end else begin
                        scan_idx_q  <= '0;
                        min_found_q <= 1'b0;
                        min_val_q   <= Inf;
                        state_q     <= StScan;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_read_enable_o = mem_en_q;
    assign mem_addr_o        = mem_addr_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign error_o           = error_q;
    assign reachable_o       = reachable_q;
    assign distance_o        = distance_q;
    assign prev_query_data_o = prev_q[prev_query_index_i];
endmodule

// File: tb/tb_dijkstra_lane_engine.sv
// Randomized and directed bench for dijkstra_lane_engine against a plain Dijkstra reference.
module tb_dijkstra_lane_engine;
    localparam int LANES = 2;
    localparam int INF   = 255;
`ifdef DIJKSTRA_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n, start;
    logic [3:0]  source, destination, pq_idx, pq_data;
    logic [4:0]  nnodes;
    logic [15:0] base, mem_addr, mem_data;
    logic        mem_en, mem_rdy, busy, done, error, reachable;
    logic [7:0]  distance;

    int vectors = 0, miscompares = 0;
    int adj [16][16];
    int cfg_n = 1, cfg_base = 0, cfg_stall = 0;
    int read_count, en_cycles, addr_viol, range_viol, stall_cnt;
    bit en_prev, acc_prev;
    logic [15:0] addr_prev;
    int m_dist [16];
    int m_prev [16];
    int m_reads;

    dijkstra_lane_engine dut (
        .clock_i(clock), .reset_ni(reset_n), .start_i(start), .source_i(source),
        .destination_i(destination), .number_of_nodes_i(nnodes), .base_address_i(base),
        .mem_read_enable_o(mem_en), .mem_addr_o(mem_addr), .mem_read_ready_i(mem_rdy),
        .mem_read_data_i(mem_data), .busy_o(busy), .done_o(done), .error_o(error),
        .reachable_o(reachable), .distance_o(distance), .prev_query_index_i(pq_idx),
        .prev_query_data_o(pq_data)
    );

    always #5 clock = ~clock;

    // Reference: textbook Dijkstra, lowest index wins ties, strict-less relaxation, sums >= 255 are INF.
    function automatic void model(input int n, input int src, input int dst, input bit early);
        bit vis [16];
        int g, best, alt;
        g = (n + LANES - 1) / LANES;
        m_reads = 0;
        for (int i = 0; i < 16; i++) begin
            m_dist[i] = INF; m_prev[i] = 15; vis[i] = 1'b0;
        end
        m_dist[src] = 0;
        for (int step = 0; step < n; step++) begin
            best = -1;
            for (int i = 0; i < n; i++)
                if (!vis[i] && (best < 0 || m_dist[i] < m_dist[best])) best = i;
            if (best < 0 || m_dist[best] == INF) break;
            vis[best] = 1'b1;
            if (early && best == dst) break;
            m_reads += g;
            for (int k = 0; k < n; k++) begin
                if (!vis[k] && adj[best][k] != INF) begin
                    alt = m_dist[best] + adj[best][k];
                    if (alt > INF) alt = INF;
                    if (alt < m_dist[k]) begin
                        m_dist[k] = alt; m_prev[k] = best;
                    end
                end
            end
        end
    endfunction

    function automatic logic [15:0] lookup(input logic [15:0] a);
        int off, row, g, gc, col;
        logic [15:0] d;
        gc  = (cfg_n + LANES - 1) / LANES;
        off = int'(a) - cfg_base;
        d   = '0;
        if (off < 0 || gc == 0) begin
            range_viol++;
            return 16'hFFFF;
        end
        row = off / gc;
        g   = off % gc;
        if (row >= cfg_n) range_viol++;
        for (int j = 0; j < LANES; j++) begin
            col = g * LANES + j;
            // padding lanes carry an attractive weight so a leak would be visible
            if (row < cfg_n && col < cfg_n) d[j*8 +: 8] = 8'(adj[row][col]);
            else d[j*8 +: 8] = 8'd1;
        end
        return d;
    endfunction

    always @(negedge clock) begin
        if (mem_en === 1'b1) begin
            en_cycles++;
            if (en_prev && !acc_prev && mem_addr !== addr_prev) addr_viol++;
            if (stall_cnt < cfg_stall) begin
                stall_cnt++; mem_rdy = 1'b0; mem_data = 16'($urandom);
            end else begin
                stall_cnt = 0; mem_rdy = 1'b1; read_count++; mem_data = lookup(mem_addr);
            end
        end else begin
            stall_cnt = 0; mem_rdy = 1'($urandom_range(0, 1)); mem_data = 16'($urandom);
        end
        acc_prev  = (mem_en === 1'b1) && mem_rdy;
        en_prev   = (mem_en === 1'b1);
        addr_prev = mem_addr;
    end

    task automatic clear_adj();
        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) adj[r][c] = INF;
    endtask

    task automatic set_graph1();
        clear_adj();
        adj[0][1] = 4; adj[0][2] = 1; adj[2][1] = 2; adj[1][3] = 5;
    endtask

    task automatic pulse_start(input int src, input int dst, input int n, input int b);
        @(negedge clock);
        start = 1'b1; source = 4'(src); destination = 4'(dst); nnodes = 5'(n); base = 16'(b);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (done !== 1'b1 && cyc < 5000) begin
            @(negedge clock); cyc++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++; $display("FAIL run_timeout done=%b required=1", done);
        end
    endtask

    task automatic run_dij(input int src, input int dst, input int n, input int b, input int stall);
        cfg_n = n; cfg_base = b; cfg_stall = stall;
        read_count = 0; en_cycles = 0; addr_viol = 0; range_viol = 0;
        pulse_start(src, dst, n, b);
        wait_done();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        vectors++;
        if ({busy, done, error, reachable, mem_en} !== 5'b0 || distance !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs busy=%b done=%b err=%b reach=%b en=%b dist=%h required=0",
                     busy, done, error, reachable, mem_en, distance);
        end
        for (int i = 0; i < 16; i += 5) begin
            pq_idx = 4'(i); #1;
            vectors++;
            if (pq_data !== 4'hF) begin
                miscompares++; $display("FAIL reset_prev[%0d] got=%h required=f", i, pq_data);
            end
        end
    endtask

    task automatic test_graph1();
        int exp_prev [4] = '{15, 2, 0, 1};
        set_graph1();
        model(4, 0, 3, EARLY);
        run_dij(0, 3, 4, 100, 0);
        vectors++;
        if (distance !== 8'd8 || reachable !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL graph1_result dist=%0d reach=%b err=%b busy=%b required 8/1/0/0",
                     distance, reachable, error, busy);
        end
        vectors++;
        if (read_count != m_reads || range_viol != 0) begin
            miscompares++;
            $display("FAIL graph1_reads got=%0d badaddr=%0d required=%0d/0",
                     read_count, range_viol, m_reads);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock); pq_idx = 4'(i); #1;
            vectors++;
            if (pq_data !== 4'(exp_prev[i])) begin
                miscompares++;
                $display("FAIL graph1_prev[%0d] got=%0d required=%0d", i, pq_data, exp_prev[i]);
            end
        end
    endtask

    task automatic test_unreachable();
        set_graph1();
        adj[1][3] = INF;
        run_dij(0, 3, 4, 7, 0);
        vectors++;
        if (distance !== 8'hFF || reachable !== 1'b0 || error !== 1'b0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL unreachable dist=%h reach=%b err=%b done=%b required ff/0/0/1",
                     distance, reachable, error, done);
        end
    endtask

    task automatic test_saturation();
        clear_adj();
        adj[0][1] = 200; adj[1][2] = 100;
        run_dij(0, 2, 3, 0, 0);
        vectors++;
        if (distance !== 8'hFF || reachable !== 1'b0) begin
            miscompares++;
            $display("FAIL saturation dist=%h reach=%b required ff/0", distance, reachable);
        end
        pq_idx = 4'd2; #1;
        vectors++;
        if (pq_data !== 4'hF) begin
            miscompares++; $display("FAIL saturation_prev2 got=%h required=f", pq_data);
        end
        pq_idx = 4'd1; #1;
        vectors++;
        if (pq_data !== 4'd0) begin
            miscompares++; $display("FAIL saturation_prev1 got=%h required=0", pq_data);
        end
    endtask

    task automatic test_stall();
        set_graph1();
        model(4, 0, 3, EARLY);
        run_dij(0, 3, 4, 3000, 3);
        vectors++;
        if (distance !== 8'd8 || reachable !== 1'b1 || addr_viol != 0 || read_count != m_reads) begin
            miscompares++;
            $display("FAIL stall dist=%0d reach=%b addr_moves=%0d reads=%0d required 8/1/0/%0d",
                     distance, reachable, addr_viol, read_count, m_reads);
        end
        pq_idx = 4'd3; #1;
        vectors++;
        if (pq_data !== 4'd1) begin
            miscompares++; $display("FAIL stall_prev3 got=%0d required=1", pq_data);
        end
    endtask

    task automatic test_config_errors();
        int cases [4][3] = '{'{0, 0, 0}, '{4, 5, 0}, '{4, 0, 4}, '{17, 0, 0}};
        for (int c = 0; c < 4; c++) begin
            en_cycles = 0;
            pulse_start(cases[c][1], cases[c][2], cases[c][0], 0);
            @(negedge clock);
            vectors++;
            if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0 || en_cycles != 0) begin
                miscompares++;
                $display("FAIL cfg_error[%0d] done=%b err=%b busy=%b reads=%0d required 1/1/0/0",
                         c, done, error, busy, en_cycles);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        int cyc = 0;
        set_graph1();
        cfg_n = 4; cfg_base = 50; cfg_stall = 3;
        pulse_start(0, 3, 4, 50);
        while (mem_en !== 1'b1 && cyc < 200) begin
            @(negedge clock); cyc++;
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || mem_en !== 1'b0 || cyc >= 200) begin
            miscompares++;
            $display("FAIL mid_fetch_reset busy=%b en=%b cycles=%0d required 0/0/<200",
                     busy, mem_en, cyc);
        end
        @(posedge clock);
        #2 reset_n = 1'b1;
        run_dij(0, 3, 4, 50, 1);
        vectors++;
        if (distance !== 8'd8 || reachable !== 1'b1) begin
            miscompares++;
            $display("FAIL after_reset_run dist=%0d reach=%b required 8/1", distance, reachable);
        end
    endtask

    task automatic test_back_to_back();
        set_graph1();
        cfg_n = 4; cfg_base = 0; cfg_stall = 0;
        pulse_start(0, 3, 4, 0);
        repeat (5) @(negedge clock);
        start = 1'b1; source = 4'd1; destination = 4'd0; nnodes = 5'd4;
        @(negedge clock);
        start = 1'b0;
        wait_done();
        vectors++;
        if (distance !== 8'd8 || reachable !== 1'b1) begin
            miscompares++;
            $display("FAIL start_while_busy dist=%0d reach=%b required 8/1", distance, reachable);
        end
        run_dij(0, 1, 4, 0, 0);
        vectors++;
        if (distance !== 8'd3 || reachable !== 1'b1) begin
            miscompares++;
            $display("FAIL back_to_back dist=%0d reach=%b required 3/1", distance, reachable);
        end
    endtask

    task automatic test_random();
        int n, src, dst, b, st;
        for (int t = 0; t < 25; t++) begin
            n   = $urandom_range(1, 16);
            src = $urandom_range(0, n - 1);
            dst = $urandom_range(0, n - 1);
            b   = $urandom_range(0, 60000);
            st  = $urandom_range(0, 2);
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++)
                    adj[r][c] = ($urandom_range(0, 2) == 0) ? INF : $urandom_range(1, 150);
            model(n, src, dst, EARLY);
            run_dij(src, dst, n, b, st);
            vectors++;
            if (distance !== 8'(m_dist[dst]) || reachable !== (m_dist[dst] != INF) ||
                error !== 1'b0) begin
                miscompares++;
                $display("FAIL rand[%0d] n=%0d s=%0d d=%0d dist=%0d reach=%b err=%b required %0d",
                         t, n, src, dst, distance, reachable, error, m_dist[dst]);
            end
            vectors++;
            if (read_count != m_reads || addr_viol != 0 || range_viol != 0) begin
                miscompares++;
                $display("FAIL rand_mem[%0d] reads=%0d moves=%0d badaddr=%0d required %0d/0/0",
                         t, read_count, addr_viol, range_viol, m_reads);
            end
            for (int i = 0; i < 16; i++) begin
                if (!EARLY || i >= n) begin
                    pq_idx = 4'(i); #1;
                    vectors++;
                    if (pq_data !== 4'(m_prev[i])) begin
                        miscompares++;
                        $display("FAIL rand_prev[%0d][%0d] got=%0d required=%0d",
                                 t, i, pq_data, m_prev[i]);
                    end
                end
            end
        end
    endtask

`ifdef DIJKSTRA_EARLY_EXIT_EN
    task automatic test_early_exit();
        set_graph1();
        run_dij(0, 2, 4, 0, 0);
        vectors++;
        if (distance !== 8'd1 || reachable !== 1'b1 || read_count != 2) begin
            miscompares++;
            $display("FAIL early_exit dist=%0d reach=%b reads=%0d required 1/1/2",
                     distance, reachable, read_count);
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0; start = 1'b0; source = '0; destination = '0; nnodes = '0; base = '0;
        pq_idx = '0; mem_rdy = 1'b0; mem_data = '0;
        stall_cnt = 0; en_prev = 1'b0; acc_prev = 1'b0; addr_prev = '0;
        read_count = 0; en_cycles = 0; addr_viol = 0; range_viol = 0;
        clear_adj();
        test_reset();
        test_graph1();
        test_unreachable();
        test_saturation();
        test_stall();
        test_config_errors();
        test_reset_mid_fetch();
        test_back_to_back();
        test_random();
`ifdef DIJKSTRA_EARLY_EXIT_EN
        test_early_exit();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
